// File: rtl/spi_slave_reg_ctrl.sv
`default_nettype none
// ============================================================================
// spi_slave_reg_ctrl : turns an SPI-slave byte stream into register bus cycles
// Option macro: SPI_SLAVE_REG_CTRL_AUTOINC_EN (address auto-increment) - Rev 1.0
// ============================================================================
module spi_slave_reg_ctrl #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic                  frm_start_it,
  input  logic                  frm_end_it,
  input  logic [7:0]            rx_data,
  input  logic                  rx_new_it,
  output logic [7:0]            tx_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  output logic                  err_it,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_BUS  = 3'd3,
    ST_RD_BUS  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]            bus_wdata_q, bus_wdata_d;
  logic                  err_it_q, err_it_d;
  logic                  busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] addr_adv;
  logic                  ack_seen;
  logic                  end_ev;

`ifdef SPI_SLAVE_REG_CTRL_AUTOINC_EN
  assign addr_adv = bus_addr_q + ADDR_WIDTH'(1);
`else
  assign addr_adv = bus_addr_q;
`endif

  assign ack_seen = bus_req_q & bus_ack;
  assign end_ev   = frm_end_it | ~cfg_enable;

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    err_it_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frm_start_it && cfg_enable) state_d = ST_CMD;
      end
      ST_CMD: begin
        // A request left over from a restarted frame keeps its address until acked.
        if (ack_seen) bus_req_d = 1'b0;
        if (rx_new_it) begin
          if (bus_req_q && !bus_ack) begin
            err_it_d = 1'b1;
          end else begin
            bus_addr_d = rx_data[ADDR_WIDTH-1:0];
            if (rx_data[7]) begin
              bus_req_d = 1'b1;
              bus_we_d  = 1'b0;
              state_d   = ST_RD_BUS;
            end else begin
              state_d   = ST_WR_DATA;
            end
          end
        end
      end
      ST_WR_DATA: begin
        if (rx_new_it) begin
          bus_wdata_d = rx_data;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          state_d     = ST_WR_BUS;
        end
      end
      ST_WR_BUS: begin
        if (rx_new_it) err_it_d = 1'b1;
        if (ack_seen) begin
          bus_req_d  = 1'b0;
          bus_addr_d = addr_adv;
          state_d    = ST_WR_DATA;
        end
      end
      ST_RD_BUS: begin
        if (rx_new_it) err_it_d = 1'b1;
        if (ack_seen) begin
          tx_data_d  = bus_rdata;
          bus_req_d  = 1'b0;
          bus_addr_d = addr_adv;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rx_new_it) begin
          bus_req_d = 1'b1;
          bus_we_d  = 1'b0;
          state_d   = ST_RD_BUS;
        end
      end
      ST_DRAIN: begin
        if (ack_seen) begin
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame-level events override the byte handling above, which has already run.
    if (state_q != ST_IDLE) begin
      if (frm_start_it && cfg_enable) begin
        err_it_d = 1'b1;
        state_d  = ST_CMD;
      end else if (state_q != ST_DRAIN && end_ev) begin
        state_d  = bus_req_d ? ST_DRAIN : ST_IDLE;
      end
    end

    if (state_d == ST_IDLE) tx_data_d = 8'h00;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_data_q   <= 8'h00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 8'h00;
      err_it_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      err_it_q    <= err_it_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign err_it    = err_it_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_reg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_slave_reg_ctrl : directed and randomized frames checked against a
// transaction-level model of the SPI register controller - Rev 1.0
// ============================================================================
module tb_spi_slave_reg_ctrl;

`ifdef SPI_SLAVE_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_enable = 1'b1;
  logic       frm_start_it = 1'b0;
  logic       frm_end_it = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_new_it = 1'b0;
  logic [7:0] tx_data;
  logic       bus_req;
  logic       bus_we;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       err_it;
  logic       busy;

  spi_slave_reg_ctrl #(.ADDR_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
    .frm_start_it(frm_start_it), .frm_end_it(frm_end_it),
    .rx_data(rx_data), .rx_new_it(rx_new_it), .tx_data(tx_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .err_it(err_it), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int ack_dly = 2;
  bit model_on = 1'b0;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_tx = 8'h00;
  logic [15:0] act_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  rdata_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] tr(input logic we, input logic [6:0] a, input logic [7:0] d);
    return {we, a, (we ? d : 8'h00)};
  endfunction

  function automatic logic [6:0] adv(input logic [6:0] a, input int i);
    return AUTOINC ? 7'(int'(a) + i) : a;
  endfunction

  // Bus responder plus per-cycle model comparison, all sampled on the falling edge.
  initial begin : monitor
    bit         waiting;
    int         wait_cnt;
    logic [15:0] snap;
    waiting = 1'b0; wait_cnt = 0; snap = '0;
    bus_ack = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (err_it) err_cnt++;
      if (model_on) begin
        chk("busy", busy, exp_busy);
        chk("tx_data", tx_data, exp_tx);
        chk("err_it", err_it, 0);
        if (frm_start_it && cfg_enable) exp_busy = 1'b1;
        else if (frm_end_it) begin exp_busy = 1'b0; exp_tx = 8'h00; end
      end
      if (bus_ack) begin
        bus_ack = 1'b0;
      end else if (bus_req && !rst) begin
        if (!waiting) begin
          waiting = 1'b1; wait_cnt = ack_dly; snap = {bus_we, bus_addr, bus_wdata};
        end else begin
          chk("bus_stable", {bus_we, bus_addr, bus_wdata}, snap);
        end
        wait_cnt--;
        if (wait_cnt <= 0) begin
          if (rdata_q.size() > 0) bus_rdata = rdata_q.pop_front();
          else bus_rdata = 8'($urandom);
          act_q.push_back(tr(bus_we, bus_addr, bus_wdata));
          if (!bus_we && model_on) exp_tx = bus_rdata;
          bus_ack = 1'b1;
          waiting = 1'b0;
        end
      end else begin
        waiting = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask
  task automatic idle(input int k);
    repeat (k) cyc();
  endtask
  task automatic pulse_start();
    frm_start_it = 1'b1; cyc(); frm_start_it = 1'b0;
  endtask
  task automatic pulse_end();
    frm_end_it = 1'b1; cyc(); frm_end_it = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_new_it = 1'b1; cyc(); rx_new_it = 1'b0;
  endtask
  task automatic wait_req_low();
    int n = 0;
    while (bus_req && n < 100) begin cyc(); n++; end
    chk("req_release", bus_req, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int e0;
    logic rw;
    logic [6:0] a;
    logic [7:0] d;
    int n;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_req", {bus_req, bus_we, bus_addr, bus_wdata, err_it}, 0);
    @(posedge clk); #2 rst = 1'b0;
    idle(2);

    // Write burst: command 0x05 then 0xAA, 0xBB.
    act_q.delete(); ack_dly = 2; e0 = err_cnt;
    pulse_start();
    send_byte(8'h05);
    send_byte(8'hAA);
    chk("wr_req_latency", {bus_req, bus_we, bus_addr, bus_wdata}, {1'b1, 1'b1, 7'h05, 8'hAA});
    wait_req_low();
    send_byte(8'hBB);
    wait_req_low();
    pulse_end();
    chk("wr_idle", busy, 0);
    idle(2);
    chk("wr_err", err_cnt - e0, 0);
    chk("wr_ntrans", act_q.size(), 2);
    if (act_q.size() == 2) begin
      chk("wr_trans0", act_q[0], tr(1'b1, 7'h05, 8'hAA));
      chk("wr_trans1", act_q[1], tr(1'b1, AUTOINC ? 7'h06 : 7'h05, 8'hBB));
    end

    // Read burst with prefetch: command 0x90, rdata 0x11 then 0x22.
    act_q.delete(); rdata_q.delete(); rdata_q.push_back(8'h11); rdata_q.push_back(8'h22);
    pulse_start();
    send_byte(8'h90);
    chk("rd_req", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 7'h10});
    wait_req_low();
    chk("rd_tx0", tx_data, 8'h11);
    send_byte(8'h3C);
    wait_req_low();
    chk("rd_tx1", tx_data, 8'h22);
    pulse_end();
    chk("rd_tx_cleared", tx_data, 8'h00);
    idle(2);
    chk("rd_ntrans", act_q.size(), 2);
    if (act_q.size() == 2) begin
      chk("rd_trans0", act_q[0], tr(1'b0, 7'h10, 8'h00));
      chk("rd_trans1", act_q[1], tr(1'b0, AUTOINC ? 7'h11 : 7'h10, 8'h00));
    end

    // Address wrap at the top of the register space.
    act_q.delete();
    pulse_start();
    send_byte(8'h7F);
    send_byte(8'h01); wait_req_low();
    send_byte(8'h02); wait_req_low();
    pulse_end(); idle(2);
    chk("wrap_ntrans", act_q.size(), 2);
    if (act_q.size() == 2) begin
      chk("wrap_trans0", act_q[0], tr(1'b1, 7'h7F, 8'h01));
      chk("wrap_trans1", act_q[1], tr(1'b1, AUTOINC ? 7'h00 : 7'h7F, 8'h02));
    end

    // Overrun: second byte arrives while the write is still waiting for ack.
    act_q.delete(); ack_dly = 20; e0 = err_cnt;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h44);
    idle(3);
    send_byte(8'h55);
    idle(1);
    chk("ovr_req_held", {bus_req, bus_wdata}, {1'b1, 8'h44});
    wait_req_low();
    pulse_end(); idle(2);
    chk("ovr_err_pulses", err_cnt - e0, 1);
    chk("ovr_ntrans", act_q.size(), 1);
    if (act_q.size() == 1) chk("ovr_trans", act_q[0], tr(1'b1, 7'h03, 8'h44));

    // Frame end while a read is outstanding: request held until ack.
    act_q.delete(); ack_dly = 5;
    pulse_start();
    send_byte(8'hA0);
    pulse_end();
    chk("drain_hold", {bus_req, busy}, 2'b11);
    wait_req_low();
    chk("drain_idle", {busy, tx_data}, 9'h000);
    chk("drain_ntrans", act_q.size(), 1);
    idle(2);

    // Restart while busy: error pulse and back to command decoding.
    ack_dly = 2; e0 = err_cnt;
    pulse_start();
    send_byte(8'h04);
    pulse_start();
    idle(1);
    chk("restart_err", err_cnt - e0, 1);
    chk("restart_busy", busy, 1);
    send_byte(8'h84);
    chk("restart_cmd", {bus_req, bus_we, bus_addr}, {1'b1, 1'b0, 7'h04});
    wait_req_low();
    pulse_end(); idle(2);

    // cfg_enable dropping mid-frame ends the frame.
    pulse_start();
    send_byte(8'h06);
    cfg_enable = 1'b0; cyc(); cfg_enable = 1'b1;
    chk("cfg_drop_idle", {busy, bus_req}, 2'b00);
    idle(2);

    // Reset in the middle of a write bus cycle.
    act_q.delete(); ack_dly = 10;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h77);
    idle(2);
    chk("pre_rst_req", bus_req, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_outs", {tx_data, bus_req, bus_we, bus_addr, bus_wdata, err_it, busy}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    pulse_start();
    chk("post_rst_start", busy, 1);
    pulse_end(); idle(2);
    chk("midrst_ntrans", act_q.size(), 0);

    // Randomized frames against the transaction model.
    model_on = 1'b1;
    for (int f = 0; f < 30; f++) begin
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 7'(126 + $urandom_range(0, 1)) : 7'($urandom);
      n  = int'($urandom_range(1, 4));
      ack_dly = int'($urandom_range(1, 4));
      act_q.delete(); exp_q.delete();
      pulse_start();
      idle(int'($urandom_range(0, 2)));
      send_byte({rw, a});
      if (rw) begin
        exp_q.push_back(tr(1'b0, a, 8'h00));
        wait_req_low();
        for (int i = 1; i <= n; i++) begin
          idle(int'($urandom_range(0, 2)));
          send_byte(8'($urandom));
          exp_q.push_back(tr(1'b0, adv(a, i), 8'h00));
          wait_req_low();
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          idle(int'($urandom_range(0, 2)));
          d = 8'($urandom);
          send_byte(d);
          exp_q.push_back(tr(1'b1, adv(a, i), d));
          wait_req_low();
        end
      end
      idle(int'($urandom_range(0, 2)));
      pulse_end();
      idle(2);
      chk("rand_ntrans", act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
        chk("rand_trans", act_q[i], exp_q[i]);
    end
    model_on = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
